// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  localparam int UART_MAX_REQ = 4;
  // Width of a requester index, sized for the largest legal requester count.
  localparam int UART_IDX_W   = 2;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request scanning upward from last+1, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; it only looks at the request vector.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [UART_IDX_W-1:0] last,
  output logic [N_REQ-1:0]      win,
  output logic                  any
);

  int   idx;
  logic found;

  // Walk the N_REQ positions after 'last' in priority order; the first request seen wins.
  always_comb begin
    win   = '0;
    any   = |req;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          win[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the UART transmitter to one source per message (round-robin), one-byte output buffer.
// Latency: request to grant 1 clock; accepted byte appears on tx_data 1 clock later.
// Backpressure: tx_ready low holds the buffered byte and drops in_ready on the granted lane.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int GAP_CLOCKS = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     in_valid,
  input  logic [8*N_REQ-1:0]   in_data,
  input  logic [N_REQ-1:0]     in_last,
  output logic [N_REQ-1:0]     in_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 msg_done
);

  // The gap counter is loaded with GAP_CLOCKS-1 so GAP lasts exactly GAP_CLOCKS cycles.
  localparam logic [15:0]           GAP_LOAD = (GAP_CLOCKS > 0) ? 16'(GAP_CLOCKS - 1) : 16'd0;
  localparam logic [UART_IDX_W-1:0] LAST_RST = UART_IDX_W'(N_REQ - 1);

  arb_state_t              state_q, state_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [UART_IDX_W-1:0]   last_q, last_d;
  logic [15:0]             gap_cnt_q, gap_cnt_d;
  logic                    tx_valid_q, tx_valid_d;
  byte_t                   tx_data_q, tx_data_d;
  logic                    msg_done_q, msg_done_d;

  logic                    buf_free;
  logic                    lane_xfer;
  byte_t                   sel_data;
  logic                    sel_last;
  logic [N_REQ-1:0]        pick_win;
  logic                    pick_any;
  logic [UART_IDX_W-1:0]   win_idx;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (in_valid),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  assign buf_free  = !tx_valid_q || tx_ready;
  assign in_ready  = ((state_q == SEND) && buf_free) ? grant_q : '0;
  assign lane_xfer = |(in_valid & in_ready);

  // Mux the granted lane's byte/last flag and encode the picker's one-hot winner.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    win_idx  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant_q[j]) begin
        sel_data = in_data[8*j +: 8];
        sel_last = in_last[j];
      end
      if (pick_win[j]) begin
        win_idx = UART_IDX_W'(j);
      end
    end
  end

  // Next-state for the arbitration FSM and the single-entry output buffer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    gap_cnt_d  = gap_cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    msg_done_d = 1'b0;

    if (lane_xfer) begin
      tx_valid_d = 1'b1;
      tx_data_d  = sel_data;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          last_d  = win_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (lane_xfer && sel_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The message is complete once the buffer is empty or empties this cycle.
        if (buf_free) begin
          msg_done_d = 1'b1;
          grant_d    = '0;
          gap_cnt_d  = GAP_LOAD;
          state_d    = (GAP_CLOCKS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all state; reset discards any buffered byte without signalling msg_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      gap_cnt_q  <= 16'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      msg_done_q <= msg_done_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign msg_done = msg_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte scoreboard.
// Two instances: GAP_CLOCKS=0 (a_*) and GAP_CLOCKS=3 (b_*); 'sel' picks which one drives the sources.
// Inputs change on the falling edge, outputs are sampled 1ns later.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tx_ready;
  logic [1:0]  in_valid, in_last;
  logic [15:0] in_data;

  logic [1:0]  a_in_ready, a_grant, b_in_ready, b_grant;
  logic [7:0]  a_tx_data, b_tx_data;
  logic        a_tx_valid, a_busy, a_msg_done, b_tx_valid, b_busy, b_msg_done;

  uart_tx_arbiter #(.N_REQ(2), .GAP_CLOCKS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .grant(a_grant), .busy(a_busy), .msg_done(a_msg_done));

  uart_tx_arbiter #(.N_REQ(2), .GAP_CLOCKS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .grant(b_grant), .busy(b_busy), .msg_done(b_msg_done));

  logic        sel;
  logic [1:0]  m_in_ready, m_grant;
  logic [7:0]  m_tx_data;
  logic        m_tx_valid, m_busy, m_msg_done;
  assign m_in_ready = sel ? b_in_ready : a_in_ready;
  assign m_grant    = sel ? b_grant    : a_grant;
  assign m_tx_data  = sel ? b_tx_data  : a_tx_data;
  assign m_tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_msg_done = sel ? b_msg_done : a_msg_done;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = -1;
  logic        rst_nxt, tx_ready_nxt;
  logic        prev_done = 1'b0;
  logic [1:0]  prev_grant = 2'b00;
  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [7:0]  exp_q[$];
  logic [1:0]  grant_log[$];
  int          gap_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] glog(input int k);
    if (k < grant_log.size()) return 32'(grant_log[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gapl(input int k);
    if (k < gap_log.size()) return 32'(gap_log[k]);
    return 32'hFFFF_FFFF;
  endfunction

  // One clock: drive on the falling edge, then observe handshakes, scoreboard and pulse rules.
  task automatic cycle();
    logic [8:0] e;
    @(negedge clk);
    rst_n    = rst_nxt;
    tx_ready = tx_ready_nxt;
    if (src0.size() > 0) begin
      e = src0[0]; in_valid[0] = 1'b1; in_data[7:0] = e[7:0]; in_last[0] = e[8];
    end else begin
      in_valid[0] = 1'b0; in_data[7:0] = 8'h00; in_last[0] = 1'b0;
    end
    if (src1.size() > 0) begin
      e = src1[0]; in_valid[1] = 1'b1; in_data[15:8] = e[7:0]; in_last[1] = e[8];
    end else begin
      in_valid[1] = 1'b0; in_data[15:8] = 8'h00; in_last[1] = 1'b0;
    end
    #1;
    cyc++;
    if (rst_n) begin
      if (m_tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected_byte", 32'(exp_q.size()), 32'd1);
        else chk("tx_byte", 32'(m_tx_data), 32'(exp_q.pop_front()));
      end
      chk("in_ready_onehot", 32'($countones(m_in_ready) <= 1), 32'd1);
      if (prev_done) chk("msg_done_twice", 32'(m_msg_done), 32'd0);
      if (m_msg_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        chk("grant_clear_on_done", 32'(m_grant), 32'd0);
      end
      if (m_grant != 2'b00 && prev_grant == 2'b00) begin
        grant_log.push_back(m_grant);
        if (last_done_cyc >= 0) gap_log.push_back(cyc - last_done_cyc);
      end
      if (in_valid[0] && m_in_ready[0]) void'(src0.pop_front());
      if (in_valid[1] && m_in_ready[1]) void'(src1.pop_front());
    end
    prev_done  = m_msg_done;
    prev_grant = m_grant;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0 && !m_busy) && n < budget);
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    last_done_cyc = -1;
  endtask

  initial begin
    int n;
    int d0;
    logic [7:0] held;
    rst_n = 1'b0; rst_nxt = 1'b0; tx_ready = 1'b1; tx_ready_nxt = 1'b1; sel = 1'b0;
    in_valid = 2'b00; in_data = 16'h0000; in_last = 2'b00;

    // Reset with both lanes requesting.
    src0.push_back({1'b1, 8'hA0}); src1.push_back({1'b1, 8'hB0});
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB0);
    repeat (4) cycle();
    chk("rst_grant", 32'(a_grant), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("rst_tx_data", 32'(a_tx_data), 32'd0);
    chk("rst_msg_done", 32'(a_msg_done), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_b_grant", 32'(b_grant), 32'd0);
    rst_nxt = 1'b1;
    clear_logs();
    wait_idle("reset_release", 40);
    chk("first_grant_after_reset", glog(0), 32'h1);

    // Contention: "HI" on lane0, "OK" on lane1, both valid together.
    clear_logs(); d0 = done_cnt;
    src0.push_back({1'b0, 8'h48}); src0.push_back({1'b1, 8'h49});
    src1.push_back({1'b0, 8'h4F}); src1.push_back({1'b1, 8'h4B});
    exp_q.push_back(8'h48); exp_q.push_back(8'h49); exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    wait_idle("hi_ok", 40);
    chk("hi_ok_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("hi_ok_grant0", glog(0), 32'h1);
    chk("hi_ok_grant1", glog(1), 32'h2);
    chk("hi_ok_gap_cycles", gapl(0), 32'd1);

    // Fairness: eight single-byte messages, both lanes always requesting.
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      src0.push_back({1'b1, 8'(8'h10 + k)}); src1.push_back({1'b1, 8'(8'h20 + k)});
      exp_q.push_back(8'(8'h10 + k)); exp_q.push_back(8'(8'h20 + k));
    end
    wait_idle("fair", 200);
    chk("fair_grant_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("fair_grant", glog(k), (k % 2 == 1) ? 32'h2 : 32'h1);

    // Backpressure: stall the transmitter for 5 clocks inside a 5-byte message.
    for (int k = 0; k < 5; k++) begin
      src0.push_back({(k == 4), 8'(8'h30 + k)});
      exp_q.push_back(8'(8'h30 + k));
    end
    n = 0;
    while (!m_tx_valid && n < 20) begin cycle(); n++; end
    chk("bp_start_timeout", 32'(n < 20), 32'd1);
    tx_ready_nxt = 1'b0;
    held = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    repeat (5) begin
      cycle();
      chk("bp_tx_valid", 32'(m_tx_valid), 32'd1);
      chk("bp_tx_data_stable", 32'(m_tx_data), 32'(held));
      chk("bp_in_ready", 32'(m_in_ready), 32'd0);
    end
    tx_ready_nxt = 1'b1;
    wait_idle("bp", 40);

    // Idle gap of 3 clocks, observed on the GAP_CLOCKS=3 instance.
    rst_nxt = 1'b0; repeat (2) cycle();
    sel = 1'b1; rst_nxt = 1'b1; cycle();
    clear_logs(); d0 = done_cnt;
    src0.push_back({1'b0, 8'h50}); src0.push_back({1'b1, 8'h51}); src1.push_back({1'b1, 8'h60});
    exp_q.push_back(8'h50); exp_q.push_back(8'h51); exp_q.push_back(8'h60);
    wait_idle("gap", 60);
    chk("gap_grant_order", glog(1), 32'h2);
    chk("gap_spacing", gapl(0), 32'd4);
    chk("gap_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Reset after 2 of 5 bytes; the message must restart from byte 0 with lane0 first.
    rst_nxt = 1'b0; sel = 1'b0; repeat (2) cycle();
    rst_nxt = 1'b1; cycle();
    for (int k = 0; k < 5; k++) begin
      src0.push_back({(k == 4), 8'(8'h70 + k)});
      exp_q.push_back(8'(8'h70 + k));
    end
    src1.push_back({1'b1, 8'h80});
    n = 0;
    while (src0.size() > 3 && n < 20) begin cycle(); n++; end
    chk("rm_start_timeout", 32'(n < 20), 32'd1);
    d0 = done_cnt;
    rst_nxt = 1'b0; cycle();
    rst_nxt = 1'b1;
    src0.delete(); src1.delete(); exp_q.delete(); clear_logs();
    for (int k = 0; k < 5; k++) begin
      src0.push_back({(k == 4), 8'(8'h70 + k)});
      exp_q.push_back(8'(8'h70 + k));
    end
    src1.push_back({1'b1, 8'h80}); exp_q.push_back(8'h80);
    cycle();
    chk("rm_tx_valid", 32'(m_tx_valid), 32'd0);
    chk("rm_grant", 32'(m_grant), 32'd0);
    chk("rm_msg_done", 32'(m_msg_done), 32'd0);
    wait_idle("rst_mid", 60);
    chk("rm_first_grant", glog(0), 32'h1);
    chk("rm_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
